// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a PS/2 host transmitter and its client logic.
// The client drives the byte and the request; the transmitter reports ready, completion and errors.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_err,
    input  err_code
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_err,
    output err_code
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, 11-bit frame clocked by the device, ACK check.
// Optional macro PS2_TX_RETRY_EN: resend the latched byte once after a NACK or timeout before reporting.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic           clk_50MHz,
  input  logic           rst,
  ps2_host_tx_if.slave   bus,
  input  logic           PS2Clk,
  input  logic           PS2Data,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_BITS,
    S_ACK,
    S_RELEASE
  } state_t;

  // Pad synchronisers; both lines idle high, so they reset to 1 to avoid a false fall after reset.
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;
  logic       sync_clk;
  logic       sync_data;
  logic       fall;

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each stage capture the previous stage's old value.
      clk_sync  <= {clk_sync[0], PS2Clk};
      data_sync <= {data_sync[0], PS2Data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign sync_clk  = clk_sync[1];
  assign sync_data = data_sync[1];
  assign fall      = clk_prev & ~sync_clk;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [9:0]       frame_q, frame_d;
  logic             drive_q, drive_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             fail;
  logic [1:0]       fail_code;
`ifdef PS2_TX_RETRY_EN
  logic             retry_q, retry_d;
`endif

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      drive_q <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
`ifdef PS2_TX_RETRY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      drive_q <= drive_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
`ifdef PS2_TX_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    drive_d   = drive_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    fail      = 1'b0;
    fail_code = ERR_TIMEOUT;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (bus.tx_valid) begin
          frame_d = {1'b1, ~^bus.tx_data, bus.tx_data};
          state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end

      S_INHIBIT: begin
        idx_d = '0;
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_RTS;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Fall 1 ends the start bit and puts d0 on the line.
      S_RTS: begin
        if (fall) begin
          cnt_d   = '0;
          idx_d   = 4'd1;
          drive_d = ~frame_q[0];
          state_d = S_BITS;
        end else if (cnt_q == TO_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // idx_q counts falls already seen; fall 10 releases the line for the stop bit.
      S_BITS: begin
        if (fall) begin
          cnt_d = '0;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd9) begin
            drive_d = 1'b0;
            state_d = S_ACK;
          end else begin
            drive_d = ~frame_q[idx_q];
          end
        end else if (cnt_q == TO_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_ACK: begin
        if (fall) begin
          cnt_d   = '0;
          idx_d   = 4'd11;
          ack_d   = ~sync_data;
          state_d = S_RELEASE;
        end else if (cnt_q == TO_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_RELEASE: begin
        if (sync_clk && sync_data) begin
          if (ack_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            fail      = 1'b1;
            fail_code = ERR_NACK;
          end
        end else if (cnt_q == TO_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      cnt_d   = '0;
      drive_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        state_d = S_INHIBIT;
      end else begin
        err_d   = 1'b1;
        code_d  = fail_code;
        state_d = S_IDLE;
      end
`else
      err_d   = 1'b1;
      code_d  = fail_code;
      state_d = S_IDLE;
`endif
    end
  end

  // Line drivers decode straight from state so an asynchronous reset releases both lines at once.
  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    unique case (state_q)
      S_INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = (cnt_q == INH_LAST);
      end
      S_RTS:   ps2_data_oe = 1'b1;
      S_BITS:  ps2_data_oe = drive_q;
      default: ps2_data_oe = 1'b0;
    endcase
  end

  assign bus.tx_ready = (state_q == S_IDLE);
  assign bus.tx_done  = done_q;
  assign bus.tx_err   = err_q;
  assign bus.err_code = code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain PS/2 lines with a behavioural keyboard model.
module tb_ps2_host_tx;
  localparam int INH  = 50;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  logic clk_50MHz = 1'b0;
  logic rst;
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic PS2Clk, PS2Data;

  always #10 clk_50MHz = ~clk_50MHz;

  assign PS2Clk  = ~(ps2_clk_oe  | dev_clk_low);
  assign PS2Data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk_50MHz   (clk_50MHz),
    .rst         (rst),
    .bus         (bus),
    .PS2Clk      (PS2Clk),
    .PS2Data     (PS2Data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line monitor, sampled on the falling clock edge.
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int inh_run = 0, inh_start_run = 0, inh_len = 0, inh_start = 0, inh_runs = 0;
  int last_release_cyc = 0, err_cyc = 0;

  always @(negedge clk_50MHz) begin
    cyc++;
    if (bus.tx_done) done_cnt++;
    if (bus.tx_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.tx_done && bus.tx_err) both_cnt++;
    if (ps2_clk_oe) begin
      inh_run++;
      if (ps2_data_oe) inh_start_run++;
    end else if (inh_run != 0) begin
      inh_len          = inh_run;
      inh_start        = inh_start_run;
      inh_runs++;
      last_release_cyc = cyc;
      inh_run          = 0;
      inh_start_run    = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk_50MHz);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk_50MHz);
    bus.tx_valid = 1'b0;
    bus.tx_data  = ~b;
    check("ready_low_after_accept", 32'(bus.tx_ready), 32'd0);
  endtask

  // Keyboard model: waits for request-to-send, clocks n_falls falls, samples the line before each rise.
  task automatic device_frame(input bit ack, input int n_falls, output logic [10:0] rx);
    int t;
    rx = '0;
    t = 0;
    while (!ps2_clk_oe && t < 10000) begin @(negedge clk_50MHz); t++; end
    check("dev_inhibit_seen", 32'(ps2_clk_oe), 32'd1);
    t = 0;
    while (ps2_clk_oe && t < 10000) begin @(negedge clk_50MHz); t++; end
    check("dev_rts_seen", 32'(ps2_clk_oe), 32'd0);
    repeat (10) @(negedge clk_50MHz);
    rx[0] = PS2Data;
    for (int k = 1; k <= n_falls && k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk_50MHz);
      rx[k] = PS2Data;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk_50MHz);
    end
    if (n_falls >= 11) begin
      dev_data_low = ack;
      repeat (10) @(negedge clk_50MHz);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk_50MHz);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk_50MHz);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_outcome(input int d0, input int e0, input int budget);
    int t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < budget) begin
      @(negedge clk_50MHz);
      t++;
    end
    check("outcome_seen", 32'((done_cnt != d0) || (err_cnt != e0)), 32'd1);
    repeat (20) @(negedge clk_50MHz);
  endtask

  logic [10:0] rx, rx2;
  int d0, e0, r0;

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk_50MHz);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_done_err", 32'({bus.tx_done, bus.tx_err}), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk_50MHz);

    // 1: 0xED acknowledged; frame {stop,par,d7..d0,start} = 1,1,1110_1101,0
    d0 = done_cnt; e0 = err_cnt;
    fork
      send(8'hED);
      device_frame(1'b1, 11, rx);
    join
    wait_outcome(d0, e0, 5000);
    check("t1_frame", 32'(rx), 32'h7DA);
    check("t1_inhibit_len", 32'(inh_len), 32'(INH));
    check("t1_start_in_inhibit", 32'(inh_start), 32'd1);
    check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t1_err_pulses", 32'(err_cnt - e0), 32'd0);
    check("t1_ready_after", 32'(bus.tx_ready), 32'd1);
    check("t1_lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

    // 2: 0xF4 acknowledged; parity 0 -> 1,0,1111_0100,0
    d0 = done_cnt; e0 = err_cnt;
    fork
      send(8'hF4);
      device_frame(1'b1, 11, rx);
    join
    wait_outcome(d0, e0, 5000);
    check("t2_frame", 32'(rx), 32'h5E8);
    check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t2_err_code_held", 32'(bus.err_code), 32'd0);

    // 6: a second request while busy is ignored
    d0 = done_cnt; e0 = err_cnt; r0 = inh_runs;
    fork
      send(8'hED);
      device_frame(1'b1, 11, rx);
      begin
        repeat (300) @(negedge clk_50MHz);
        bus.tx_data  = 8'hAA;
        bus.tx_valid = 1'b1;
        @(negedge clk_50MHz);
        bus.tx_valid = 1'b0;
      end
    join
    wait_outcome(d0, e0, 5000);
    repeat (100) @(negedge clk_50MHz);
    check("t6_frame", 32'(rx), 32'h7DA);
    check("t6_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("t6_single_frame", 32'(inh_runs - r0), 32'd1);

    // 3: 0x55 NACKed; parity 1 -> 1,1,0101_0101,0
    d0 = done_cnt; e0 = err_cnt;
    fork
      send(8'h55);
      begin
        device_frame(1'b0, 11, rx);
`ifdef PS2_TX_RETRY_EN
        device_frame(1'b0, 11, rx2);
        check("t3_retry_frame", 32'(rx2), 32'h6AA);
`endif
      end
    join
    wait_outcome(d0, e0, 5000);
    check("t3_frame", 32'(rx), 32'h6AA);
    check("t3_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("t3_done_pulses", 32'(done_cnt - d0), 32'd0);
    check("t3_err_code", 32'(bus.err_code), 32'd1);

    // 4: device silent after request-to-send -> timeout 2000 cycles after clock release
    d0 = done_cnt; e0 = err_cnt;
    send(8'h12);
    wait_outcome(d0, e0, 10000);
    check("t4_timeout_latency", 32'(err_cyc - last_release_cyc), 32'(TO));
    check("t4_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("t4_err_code", 32'(bus.err_code), 32'd2);
    check("t4_lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("t4_ready", 32'(bus.tx_ready), 32'd1);

    // 5: reset after fall 5 of 0xA5 (d4=0, so data is being pulled low)
    d0 = done_cnt; e0 = err_cnt;
    fork
      send(8'hA5);
      device_frame(1'b1, 5, rx);
    join
    check("t5_busy", 32'(bus.tx_ready), 32'd0);
    check("t5_data_driven", 32'(ps2_data_oe), 32'd1);
    r0 = inh_runs;
    rst = 1'b1;
    #1;
    check("t5_rst_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("t5_rst_ready", 32'(bus.tx_ready), 32'd1);
    repeat (3) @(negedge clk_50MHz);
    rst = 1'b0;
    repeat (100) @(negedge clk_50MHz);
    check("t5_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    check("t5_err_code_cleared", 32'(bus.err_code), 32'd0);
    check("t5_no_new_frame", 32'(inh_runs - r0), 32'd0);

    check("done_err_exclusive", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule
